// File: rtl/mul_div_unit.sv
// mul_div_unit: HI/LO multiply/divide unit attached to the EXE stage.
// Holds EXE (md_ready_out low) until a MULT/MULTU/DIV/DIVU result is written
// to HI/LO, owns the architectural HI/LO registers and serves MFHI/MFLO reads.
// Optional build macro: MDU_MUL_SINGLE_CYCLE_EN computes multiplies in the
// start cycle and skips the MUL state.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for an MD start; MTHI/MTLO commit here
// MUL    | product of latched operands written to HI/LO this cycle
// DIV    | restoring divide, one quotient bit per cycle (counter 0..31)
// DONE   | result committed; EXE may leave, waits for mem_allowin_in
module mul_div_unit #(
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exe_valid_in,
    input  logic        exe_exception_in,
    input  logic [31:0] exe_in0_in,
    input  logic [31:0] exe_in1_in,
    input  logic [5:0]  exe_mult_div_op_in,
    input  logic        exe_read_request_in,
    input  logic        exe_read_hi_in,
    input  logic        mem_allowin_in,
    input  logic        wb_ClrStpJmp_in,
    output logic        md_ready_out,
    output logic        md_busy_out,
    output logic [31:0] md_rdata_out,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam int CW = $clog2(DIV_ITER);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t          r_state;
    logic [31:0]     r_hi;
    logic [31:0]     r_lo;
    logic [31:0]     r_op_a;     // multiplicand, or dividend shifting into quotient
    logic [31:0]     r_op_b;     // multiplier, or divisor magnitude
    logic [31:0]     r_rem;
    logic            r_signed;
    logic            r_a_neg;
    logic            r_b_neg;
    logic            r_b_zero;
    logic [CW-1:0]   r_cnt;

    logic            w_start;
    logic            w_mt_commit;
    logic [31:0]     w_a_abs;
    logic [31:0]     w_b_abs;
    logic [63:0]     w_mul_a;
    logic [63:0]     w_mul_b;
    logic [63:0]     w_prod;
    logic [32:0]     w_rem_sh;
    logic [32:0]     w_diff;
    logic            w_qbit;
    logic [31:0]     w_rem_nxt;
    logic [31:0]     w_quo_nxt;
    logic [31:0]     w_quo_fin;
    logic [31:0]     w_rem_fin;

    assign w_start     = exe_valid_in & ~exe_exception_in & (r_state == S_IDLE)
                       & (|exe_mult_div_op_in[3:0]);
    assign w_mt_commit = exe_valid_in & ~exe_exception_in & mem_allowin_in;

    // Magnitudes only matter for signed DIV (op bit 2); DIVU keeps raw values.
    assign w_a_abs = (exe_mult_div_op_in[2] & exe_in0_in[31]) ? -exe_in0_in : exe_in0_in;
    assign w_b_abs = (exe_mult_div_op_in[2] & exe_in1_in[31]) ? -exe_in1_in : exe_in1_in;

    // Sign- or zero-extend to 64 bits so one unsigned multiply covers both modes.
`ifdef MDU_MUL_SINGLE_CYCLE_EN
    assign w_mul_a = {{32{exe_mult_div_op_in[0] & exe_in0_in[31]}}, exe_in0_in};
    assign w_mul_b = {{32{exe_mult_div_op_in[0] & exe_in1_in[31]}}, exe_in1_in};
`else
    assign w_mul_a = {{32{r_signed & r_op_a[31]}}, r_op_a};
    assign w_mul_b = {{32{r_signed & r_op_b[31]}}, r_op_b};
`endif
    assign w_prod  = w_mul_a * w_mul_b;

    // One restoring step. With a zero divisor every step keeps the shifted
    // value, so the remainder ends as the dividend magnitude and re-signing
    // it reproduces the latched dividend exactly.
    assign w_rem_sh  = {r_rem, r_op_a[31]};
    assign w_diff    = w_rem_sh - {1'b0, r_op_b};
    assign w_qbit    = ~w_diff[32];
    assign w_rem_nxt = w_qbit ? w_diff[31:0] : w_rem_sh[31:0];
    assign w_quo_nxt = {r_op_a[30:0], w_qbit};
    assign w_quo_fin = (r_signed & (r_a_neg ^ r_b_neg)) ? -w_quo_nxt : w_quo_nxt;
    assign w_rem_fin = r_a_neg ? -w_rem_nxt : w_rem_nxt;

    // Control FSM, HI/LO registers and divider datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_hi     <= '0;
            r_lo     <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_rem    <= '0;
            r_signed <= 1'b0;
            r_a_neg  <= 1'b0;
            r_b_neg  <= 1'b0;
            r_b_zero <= 1'b0;
            r_cnt    <= '0;
        end else if (wb_ClrStpJmp_in) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            if (w_mt_commit & exe_mult_div_op_in[4]) r_hi <= exe_in0_in;
            if (w_mt_commit & exe_mult_div_op_in[5]) r_lo <= exe_in0_in;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        if (|exe_mult_div_op_in[1:0]) begin
`ifdef MDU_MUL_SINGLE_CYCLE_EN
                            r_hi    <= w_prod[63:32];
                            r_lo    <= w_prod[31:0];
                            r_state <= S_DONE;
`else
                            r_op_a   <= exe_in0_in;
                            r_op_b   <= exe_in1_in;
                            r_signed <= exe_mult_div_op_in[0];
                            r_state  <= S_MUL;
`endif
                        end else begin
                            r_op_a   <= w_a_abs;
                            r_op_b   <= w_b_abs;
                            r_rem    <= '0;
                            r_signed <= exe_mult_div_op_in[2];
                            r_a_neg  <= exe_mult_div_op_in[2] & exe_in0_in[31];
                            r_b_neg  <= exe_mult_div_op_in[2] & exe_in1_in[31];
                            r_b_zero <= (exe_in1_in == 32'd0);
                            r_cnt    <= '0;
                            r_state  <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    r_hi    <= w_prod[63:32];
                    r_lo    <= w_prod[31:0];
                    r_state <= S_DONE;
                end
                S_DIV: begin
                    r_op_a <= w_quo_nxt;
                    r_rem  <= w_rem_nxt;
                    r_cnt  <= r_cnt + CW'(1);
                    if (r_cnt == CW'(DIV_ITER - 1)) begin
                        r_hi    <= w_rem_fin;
                        r_lo    <= r_b_zero ? 32'hFFFF_FFFF : w_quo_fin;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (mem_allowin_in) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign md_ready_out = ~exe_valid_in | exe_exception_in
                        | (exe_mult_div_op_in[3:0] == 4'd0) | (r_state == S_DONE);
    assign md_busy_out  = (r_state == S_MUL) | (r_state == S_DIV);
    assign md_rdata_out = exe_read_request_in ? (exe_read_hi_in ? r_hi : r_lo) : 32'd0;
    assign hi_out       = r_hi;
    assign lo_out       = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed testbench for mul_div_unit with hand-computed HI/LO results.
module tb_mul_div_unit;

    localparam logic [5:0] OP_MULT  = 6'b000001;
    localparam logic [5:0] OP_MULTU = 6'b000010;
    localparam logic [5:0] OP_DIV   = 6'b000100;
    localparam logic [5:0] OP_DIVU  = 6'b001000;
    localparam logic [5:0] OP_MTHI  = 6'b010000;
    localparam logic [5:0] OP_MTLO  = 6'b100000;

`ifdef MDU_MUL_SINGLE_CYCLE_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 2;
`endif
    localparam int DIV_LAT = 33;

    logic        clk;
    logic        rst;
    logic        exe_valid_in;
    logic        exe_exception_in;
    logic [31:0] exe_in0_in;
    logic [31:0] exe_in1_in;
    logic [5:0]  exe_mult_div_op_in;
    logic        exe_read_request_in;
    logic        exe_read_hi_in;
    logic        mem_allowin_in;
    logic        wb_ClrStpJmp_in;
    logic        md_ready_out;
    logic        md_busy_out;
    logic [31:0] md_rdata_out;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int n_vec = 0;
    int n_err = 0;

    mul_div_unit #(.DIV_ITER(32)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .exe_valid_in        (exe_valid_in),
        .exe_exception_in    (exe_exception_in),
        .exe_in0_in          (exe_in0_in),
        .exe_in1_in          (exe_in1_in),
        .exe_mult_div_op_in  (exe_mult_div_op_in),
        .exe_read_request_in (exe_read_request_in),
        .exe_read_hi_in      (exe_read_hi_in),
        .mem_allowin_in      (mem_allowin_in),
        .wb_ClrStpJmp_in     (wb_ClrStpJmp_in),
        .md_ready_out        (md_ready_out),
        .md_busy_out         (md_busy_out),
        .md_rdata_out        (md_rdata_out),
        .hi_out              (hi_out),
        .lo_out              (lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        exe_valid_in        = 1'b0;
        exe_exception_in    = 1'b0;
        exe_mult_div_op_in  = 6'd0;
        exe_read_request_in = 1'b0;
        exe_read_hi_in      = 1'b0;
        mem_allowin_in      = 1'b1;
        wb_ClrStpJmp_in     = 1'b0;
    endtask

    // Issue an MD op in cycle T, verify the stall length exactly and the result.
    task automatic run_md(input string tag, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int lat,
                          input logic [31:0] eh, input logic [31:0] el);
        exe_valid_in       = 1'b1;
        exe_mult_div_op_in = op;
        exe_in0_in         = a;
        exe_in1_in         = b;
        mem_allowin_in     = 1'b1;
        #1;
        check({tag, "_rdy_T"}, {63'd0, md_ready_out}, 64'd0);
        for (int c = 1; c < lat; c++) begin
            step();
            check({tag, "_stall"}, {62'd0, md_busy_out, md_ready_out}, 64'd2);
        end
        step();
        check({tag, "_rdy_done"}, {62'd0, md_busy_out, md_ready_out}, 64'd1);
        check({tag, "_hi"}, {32'd0, hi_out}, {32'd0, eh});
        check({tag, "_lo"}, {32'd0, lo_out}, {32'd0, el});
        step();
        idle_inputs();
        #1;
        check({tag, "_idle"}, {62'd0, md_busy_out, md_ready_out}, 64'd1);
    endtask

    initial begin
        idle_inputs();
        exe_in0_in = '0;
        exe_in1_in = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        exe_read_request_in = 1'b1;
        #1;
        check("rst_ready", {63'd0, md_ready_out}, 64'd1);
        check("rst_busy",  {63'd0, md_busy_out},  64'd0);
        check("rst_rdata", {32'd0, md_rdata_out}, 64'd0);
        check("rst_hilo",  {hi_out, lo_out}, 64'd0);
        exe_read_request_in = 1'b0;

        run_md("mult",  OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_md("multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 32'hFFFF_FFFE, 32'h0000_0001);
        run_md("div_n7_2",   OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("div_100_n7", OP_DIV,  32'h0000_0064, 32'hFFFF_FFF9, DIV_LAT, 32'h0000_0002, 32'hFFFF_FFF2);
        run_md("divu_by0",   OP_DIVU, 32'h1234_5678, 32'h0000_0000, DIV_LAT, 32'h1234_5678, 32'hFFFF_FFFF);
        run_md("div_min_by0", OP_DIV, 32'h8000_0000, 32'h0000_0000, DIV_LAT, 32'h8000_0000, 32'hFFFF_FFFF);
        run_md("divu_big",   OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, DIV_LAT, 32'h0000_000F, 32'h0FFF_FFFF);

        // Flush in T+20 of a divide: abort, HI/LO untouched.
        exe_valid_in       = 1'b1;
        exe_mult_div_op_in = OP_DIV;
        exe_in0_in         = 32'd50;
        exe_in1_in         = 32'd5;
        for (int c = 1; c <= 20; c++) step();
        check("flush_busy_before", {63'd0, md_busy_out}, 64'd1);
        wb_ClrStpJmp_in = 1'b1;
        step();
        check("flush_busy_after", {63'd0, md_busy_out}, 64'd0);
        check("flush_hilo", {hi_out, lo_out}, 64'h0000_000F_0FFF_FFFF);
        idle_inputs();
        #1;
        check("flush_ready", {63'd0, md_ready_out}, 64'd1);

        // Full divide right after a flush confirms the counter restarted.
        run_md("div_n100_n7", OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, DIV_LAT, 32'hFFFF_FFFE, 32'h0000_000E);

        // MTLO whose commit edge is flushed.
        exe_valid_in       = 1'b1;
        exe_mult_div_op_in = OP_MTLO;
        exe_in0_in         = 32'hA5A5_A5A5;
        wb_ClrStpJmp_in    = 1'b1;
        #1;
        check("mtlo_flush_ready", {63'd0, md_ready_out}, 64'd1);
        step();
        check("mtlo_flush_lo", {32'd0, lo_out}, 64'h0000_0000_0000_000E);
        wb_ClrStpJmp_in = 1'b0;

        // MTHI commit, then MTHI held back by mem_allowin_in, then MTLO commit.
        exe_mult_div_op_in = OP_MTHI;
        exe_in0_in         = 32'h0BAD_F00D;
        step();
        check("mthi_hi", {32'd0, hi_out}, 64'h0000_0000_0BAD_F00D);
        mem_allowin_in = 1'b0;
        exe_in0_in     = 32'hDEAD_0000;
        step();
        check("mthi_stall_hi", {32'd0, hi_out}, 64'h0000_0000_0BAD_F00D);
        mem_allowin_in     = 1'b1;
        exe_mult_div_op_in = OP_MTLO;
        exe_in0_in         = 32'h1357_9BDF;
        step();
        check("mtlo_lo", {32'd0, lo_out}, 64'h0000_0000_1357_9BDF);
        idle_inputs();

        // Exception-carrying DIV drains without starting.
        exe_valid_in       = 1'b1;
        exe_exception_in   = 1'b1;
        exe_mult_div_op_in = OP_DIV;
        exe_in0_in         = 32'd9;
        exe_in1_in         = 32'd3;
        #1;
        check("exc_ready", {63'd0, md_ready_out}, 64'd1);
        step();
        check("exc_busy", {63'd0, md_busy_out}, 64'd0);
        check("exc_hilo", {hi_out, lo_out}, 64'h0BAD_F00D_1357_9BDF);
        idle_inputs();

        // MULT completes while MEM stalls for 5 cycles: one write, no restart.
        exe_valid_in       = 1'b1;
        exe_mult_div_op_in = OP_MULT;
        exe_in0_in         = 32'hFFFF_FFF9;
        exe_in1_in         = 32'h0000_0006;
        mem_allowin_in     = 1'b0;
        for (int c = 1; c <= MUL_LAT; c++) step();
        check("hold_ready_done", {62'd0, md_busy_out, md_ready_out}, 64'd1);
        check("hold_hilo", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFD6);
        for (int c = 0; c < 5; c++) begin
            step();
            check("hold_wait", {62'd0, md_busy_out, md_ready_out}, 64'd1);
        end
        check("hold_hilo_end", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFD6);
        mem_allowin_in = 1'b1;
        step();
        exe_mult_div_op_in  = 6'd0;
        exe_read_request_in = 1'b1;
        exe_read_hi_in      = 1'b1;
        #1;
        check("mfhi_data",  {32'd0, md_rdata_out}, 64'h0000_0000_FFFF_FFFF);
        check("mfhi_ready", {63'd0, md_ready_out}, 64'd1);
        exe_read_hi_in = 1'b0;
        #1;
        check("mflo_data", {32'd0, md_rdata_out}, 64'h0000_0000_FFFF_FFD6);
        step();
        check("hold_no_restart", {63'd0, md_busy_out}, 64'd0);
        idle_inputs();

        // Reset in the middle of a divide clears HI/LO.
        exe_valid_in       = 1'b1;
        exe_mult_div_op_in = OP_DIV;
        exe_in0_in         = 32'd1000;
        exe_in1_in         = 32'd3;
        for (int c = 0; c < 10; c++) step();
        check("rstdiv_busy", {63'd0, md_busy_out}, 64'd1);
        rst = 1'b1;
        step();
        idle_inputs();
        #1;
        check("rstdiv_hilo", {hi_out, lo_out}, 64'd0);
        check("rstdiv_state", {62'd0, md_busy_out, md_ready_out}, 64'd1);
        rst = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
